inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 16 +
 rtl/inst_queue.sv | 76 +++++++
 tb/tb_inst_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and types for the instruction queue.
// These widths and the default depth are the project-wide values that the
// fetch stage and the decoder also use.
package inst_queue_pkg;

  localparam int IDWidth        = 32;
  localparam int AddressWidth   = 32;
  localparam int InstQueueDepth = 16;

  // One queue slot: the instruction word together with its PC.
  typedef struct packed {
    logic [IDWidth-1:0]      inst;
    logic [AddressWidth-1:0] pc;
  } entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// This is a circular FIFO with show-ahead output: the head entry is visible
// combinationally.
// Either clear input discards every entry.
// A low rdy_in freezes the whole queue, and the clears are ignored while it is low.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = InstQueueDepth
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    if_instqueue_en_in,
  input  logic [IDWidth-1:0]      if_instqueue_inst_in,
  input  logic [AddressWidth-1:0] if_instqueue_pc_in,
  output logic                    instqueue_if_rdy_out,
  output logic                    instqueue_decoder_en_out,
  output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
  output logic [AddressWidth-1:0] instqueue_decoder_pc_out,
  input  logic                    decoder_instqueue_rdy_in,
  input  logic                    decoder_instqueue_clear_in,
  input  logic                    rob_instqueue_clear_in
);

  localparam int PtrWidth = $clog2(DEPTH);
  localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(DEPTH);

  logic [PtrWidth-1:0] head;
  logic [PtrWidth-1:0] tail;
  logic [PtrWidth:0]   count;
  entry_t              mem [DEPTH];

  logic clear;
  logic push;
  logic pop;

  // Handshake qualification: a clear in the same cycle blocks both sides.
  always_comb begin
    clear = decoder_instqueue_clear_in | rob_instqueue_clear_in;
    instqueue_if_rdy_out     = rdy_in & (count != FullCount) & ~clear;
    instqueue_decoder_en_out = rdy_in & (count != '0) & ~clear;
    push = if_instqueue_en_in & instqueue_if_rdy_out;
    pop  = instqueue_decoder_en_out & decoder_instqueue_rdy_in;
    instqueue_decoder_inst_out = mem[head].inst;
    instqueue_decoder_pc_out   = mem[head].pc;
  end

  // Pointer and occupancy bookkeeping. Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  // Storage has no reset; en_out keeps stale slots from ever being consumed.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[tail] <= '{inst: if_instqueue_inst_in, pc: if_instqueue_pc_in};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed testbench for inst_queue.
// Inputs change on the falling edge, and outputs are sampled just after that.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    rdy_in;
  logic                    if_instqueue_en_in;
  logic [IDWidth-1:0]      if_instqueue_inst_in;
  logic [AddressWidth-1:0] if_instqueue_pc_in;
  logic                    instqueue_if_rdy_out;
  logic                    instqueue_decoder_en_out;
  logic [IDWidth-1:0]      instqueue_decoder_inst_out;
  logic [AddressWidth-1:0] instqueue_decoder_pc_out;
  logic                    decoder_instqueue_rdy_in;
  logic                    decoder_instqueue_clear_in;
  logic                    rob_instqueue_clear_in;

  int checks = 0;
  int errors = 0;

  inst_queue #(.DEPTH(16)) dut (
    .clk_in                     (clk_in),
    .rst_in                     (rst_in),
    .rdy_in                     (rdy_in),
    .if_instqueue_en_in         (if_instqueue_en_in),
    .if_instqueue_inst_in       (if_instqueue_inst_in),
    .if_instqueue_pc_in         (if_instqueue_pc_in),
    .instqueue_if_rdy_out       (instqueue_if_rdy_out),
    .instqueue_decoder_en_out   (instqueue_decoder_en_out),
    .instqueue_decoder_inst_out (instqueue_decoder_inst_out),
    .instqueue_decoder_pc_out   (instqueue_decoder_pc_out),
    .decoder_instqueue_rdy_in   (decoder_instqueue_rdy_in),
    .decoder_instqueue_clear_in (decoder_instqueue_clear_in),
    .rob_instqueue_clear_in     (rob_instqueue_clear_in)
  );

  // Free-running system clock.
  always #5 clk_in = ~clk_in;

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Commit one rising edge, then return at the next falling edge.
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic [31:0] pc, input logic dec_rdy);
    if_instqueue_en_in       = en;
    if_instqueue_pc_in       = pc;
    if_instqueue_inst_in     = 32'hA000_0000 | pc;
    decoder_instqueue_rdy_in = dec_rdy;
    #1;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    decoder_instqueue_clear_in = 1'b0;
    rob_instqueue_clear_in     = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0);
    #2;
    check_bit("reset_en_out", instqueue_decoder_en_out, 1'b0);
    check_bit("reset_rdy_out", instqueue_if_rdy_out, 1'b1);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;

    // Fill: 16 pushes with the decoder stalled
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 32'(i * 4), 1'b0);
      check_bit("fill_rdy_out", instqueue_if_rdy_out, 1'b1);
      tick();
    end
    apply_stimulus(1'b1, 32'h40, 1'b0);
    check_bit("full_rdy_out", instqueue_if_rdy_out, 1'b0);
    check_bit("full_en_out", instqueue_decoder_en_out, 1'b1);
    tick();
    check_bit("full_17th_rdy_out", instqueue_if_rdy_out, 1'b0);

    // Drain: the first pop happens with a push still offered, which is refused at full
    apply_stimulus(1'b1, 32'h44, 1'b1);
    check_bit("full_pop_rdy_out", instqueue_if_rdy_out, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 1) apply_stimulus(1'b0, 32'h0, 1'b1);
      check_bit("drain_en_out", instqueue_decoder_en_out, 1'b1);
      check_word("drain_pc", instqueue_decoder_pc_out, 32'(i * 4));
      check_word("drain_inst", instqueue_decoder_inst_out, 32'hA000_0000 | 32'(i * 4));
      tick();
    end
    check_bit("drained_en_out", instqueue_decoder_en_out, 1'b0);
    check_bit("drained_rdy_out", instqueue_if_rdy_out, 1'b1);

    // Concurrent push and pop with five entries held in the queue
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 32'h200 + 32'(k * 4), 1'b0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 32'h200 + 32'((i + 5) * 4), 1'b1);
      check_bit("conc_en_out", instqueue_decoder_en_out, 1'b1);
      check_bit("conc_rdy_out", instqueue_if_rdy_out, 1'b1);
      check_word("conc_pc", instqueue_decoder_pc_out, 32'h200 + 32'(i * 4));
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      apply_stimulus(1'b0, 32'h0, 1'b1);
      check_bit("conc_tail_en_out", instqueue_decoder_en_out, 1'b1);
      check_word("conc_tail_pc", instqueue_decoder_pc_out, 32'h200 + 32'((40 + j) * 4));
      tick();
    end
    check_bit("conc_empty_en_out", instqueue_decoder_en_out, 1'b0);

    // Flush with seven entries while a push is offered
    for (int k = 0; k < 7; k++) begin
      apply_stimulus(1'b1, 32'h300 + 32'(k * 4), 1'b0);
      tick();
    end
    rob_instqueue_clear_in = 1'b1;
    apply_stimulus(1'b1, 32'h400, 1'b1);
    check_bit("flush_rdy_out", instqueue_if_rdy_out, 1'b0);
    check_bit("flush_en_out", instqueue_decoder_en_out, 1'b0);
    tick();
    rob_instqueue_clear_in = 1'b0;
    apply_stimulus(1'b1, 32'h500, 1'b0);
    check_bit("post_flush_en_out", instqueue_decoder_en_out, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1);
    check_word("post_flush_pc", instqueue_decoder_pc_out, 32'h500);
    tick();
    check_bit("post_flush_empty", instqueue_decoder_en_out, 1'b0);

    // The decoder clear has the same effect as the ROB clear
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b1, 32'h800 + 32'(k * 4), 1'b0);
      tick();
    end
    decoder_instqueue_clear_in = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0);
    tick();
    decoder_instqueue_clear_in = 1'b0;
    #1;
    check_bit("dec_clear_en_out", instqueue_decoder_en_out, 1'b0);

    // Empty bypass: the pushed entry reaches the head one cycle later
    apply_stimulus(1'b1, 32'h100, 1'b0);
    check_bit("bypass_same_cycle", instqueue_decoder_en_out, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0);
    check_bit("bypass_en_out", instqueue_decoder_en_out, 1'b1);
    check_word("bypass_pc", instqueue_decoder_pc_out, 32'h100);

    // Freeze with three entries while pushes, pops and a clear are requested
    for (int k = 1; k < 3; k++) begin
      apply_stimulus(1'b1, 32'h100 + 32'(k * 4), 1'b0);
      tick();
    end
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rob_instqueue_clear_in = (i == 1);
      apply_stimulus(1'b1, 32'h999, 1'b1);
      check_bit("freeze_en_out", instqueue_decoder_en_out, 1'b0);
      check_bit("freeze_rdy_out", instqueue_if_rdy_out, 1'b0);
      check_word("freeze_pc", instqueue_decoder_pc_out, 32'h100);
      tick();
    end
    rob_instqueue_clear_in = 1'b0;
    rdy_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, 32'h0, 1'b1);
      check_bit("thaw_en_out", instqueue_decoder_en_out, 1'b1);
      check_word("thaw_pc", instqueue_decoder_pc_out, 32'h100 + 32'(k * 4));
      tick();
    end
    check_bit("thaw_empty", instqueue_decoder_en_out, 1'b0);

    // Reset mid-stream clears the queue without any clock edge
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 32'h600 + 32'(k * 4), 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 32'h0, 1'b0);
    check_bit("pre_reset_en_out", instqueue_decoder_en_out, 1'b1);
    rst_in = 1'b0;
    #1;
    check_bit("async_reset_en_out", instqueue_decoder_en_out, 1'b0);
    check_bit("async_reset_rdy_out", instqueue_if_rdy_out, 1'b1);
    @(negedge clk_in);
    rst_in = 1'b1;
    apply_stimulus(1'b1, 32'h700, 1'b0);
    check_bit("post_reset_en_out", instqueue_decoder_en_out, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1);
    check_word("post_reset_pc", instqueue_decoder_pc_out, 32'h700);
    tick();
    check_bit("post_reset_empty", instqueue_decoder_en_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
